// File: rtl/float_to_int_conv.sv
// Multi-cycle IEEE-754 single to signed integer converter, saturating, denormals flushed to zero.
// Ports: clock, reset, in_valid/in_ready/Float_In (input handshake), out_valid/out_ready/Int_Out/overflow/invalid (result).
// Optional build macro FTOI_ROUND_NEAREST_EN: round-to-nearest-even (default build truncates toward zero).
module float_to_int_conv #(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          Float_In,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] Int_Out,
  output logic                 overflow,
  output logic                 invalid
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINAL, DONE} state_t;

  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  // Smallest exponent whose magnitude no longer fits the signed result.
  localparam logic [7:0] SAT_EXP = 8'(OUT_WIDTH + 126);
`ifdef FTOI_ROUND_NEAREST_EN
  // exp==126 (0.5..1) still needs the shift path so it can round up to 1.
  localparam logic [7:0] SMALL_EXP = 8'd126;
`else
  localparam logic [7:0] SMALL_EXP = 8'd127;
`endif

  state_t state, next_state;

  logic [OUT_WIDTH-1:0] acc;
  logic [5:0]           cnt;
  logic                 sign;
  logic                 left;
`ifdef FTOI_ROUND_NEAREST_EN
  logic                 guard;
  logic                 sticky;
`endif

  logic        f_sign;
  logic [7:0]  f_exp;
  logic [22:0] f_mnt;
  logic        accept;
  logic        special;
  logic [OUT_WIDTH-1:0] spec_val;
  logic        spec_ovf;
  logic        spec_inv;
  logic [OUT_WIDTH-1:0] mag;

  assign f_sign    = Float_In[31];
  assign f_exp     = Float_In[30:23];
  assign f_mnt     = Float_In[22:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    special  = 1'b1;
    spec_val = '0;
    spec_ovf = 1'b0;
    spec_inv = 1'b0;
    if (f_exp == 8'd255) begin
      spec_inv = 1'b1;
      spec_val = (f_mnt == '0 && f_sign) ? MIN_NEG : MAX_POS;
    end else if (f_exp == 8'd0 || f_exp < SMALL_EXP) begin
      spec_val = '0;
    end else if (f_exp >= SAT_EXP) begin
      // -2^(W-1) is exactly representable: no overflow.
      if (f_sign && f_exp == SAT_EXP && f_mnt == '0) begin
        spec_val = MIN_NEG;
      end else begin
        spec_val = f_sign ? MIN_NEG : MAX_POS;
        spec_ovf = 1'b1;
      end
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    mag = acc;
`ifdef FTOI_ROUND_NEAREST_EN
    if (guard && (sticky || acc[0])) begin
      mag = acc + OUT_WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (special)                next_state = DONE;
          else if (f_exp == 8'd150)   next_state = FINAL;
          else                        next_state = SHIFT;
        end
      end
      SHIFT: if (cnt == 6'd1) next_state = FINAL;
      FINAL: next_state = DONE;
      DONE:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      left     <= 1'b0;
      Int_Out  <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
      guard    <= 1'b0;
      sticky   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sign <= f_sign;
            left <= (f_exp > 8'd150);
            acc  <= OUT_WIDTH'({1'b1, f_mnt});
            cnt  <= (f_exp > 8'd150) ? 6'(f_exp - 8'd150)
                                     : 6'(8'd150 - f_exp);
`ifdef FTOI_ROUND_NEAREST_EN
            guard  <= 1'b0;
            sticky <= 1'b0;
`endif
            if (special) begin
              Int_Out  <= spec_val;
              overflow <= spec_ovf;
              invalid  <= spec_inv;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 6'd1;
          if (left) begin
            acc <= acc << 1;
          end else begin
            acc <= acc >> 1;
`ifdef FTOI_ROUND_NEAREST_EN
            guard  <= acc[0];
            sticky <= sticky | guard;
`endif
          end
        end
        FINAL: begin
          Int_Out  <= sign ? -mag : mag;
          overflow <= 1'b0;
          invalid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
